// File: rtl/irq_gen_pkg.sv
// Shared encodings for the interrupt generator: FSM states, trigger modes and
// the default acknowledge address.
package irq_gen_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ASSERT = 2'd2;

  localparam logic MODE_DELAY = 1'b0;
  localparam logic MODE_PC    = 1'b1;

  localparam logic [31:0] ACK_ADDR_DEFAULT = 32'h0000_7F20;

  // Word-address match; the byte offset bits are masked off on both sides.
  function automatic logic is_ack(input logic [31:0] addr,
                                  input logic [3:0]  byteen,
                                  input logic [31:0] ack_addr);
    return ((addr & ~32'h3) == (ack_addr & ~32'h3)) && (byteen != 4'b0000);
  endfunction

endpackage

// File: rtl/irq_gen_fifo.sv
// Synchronous FIFO for queued trigger events; the head is visible
// combinationally on pop_data_o.
module irq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 33
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/irq_gen.sv
// Interrupt generator: queued delay / PC-match triggers raise a registered
// interrupt that is held until the CPU stores to the acknowledge address.
module irq_gen
  import irq_gen_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] ACK_ADDR = ACK_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ev_valid,
  output logic        ev_ready,
  input  logic        ev_mode,
  input  logic [31:0] ev_value,
  input  logic [31:0] macroscopic_pc,
  input  logic [31:0] m_int_addr,
  input  logic [3:0]  m_int_byteen,
  output logic        interrupt,
  output logic        busy,
  output logic [4:0]  ev_count,
  output logic [15:0] irq_total
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [1:0]    state_q, state_d;
  logic          mode_q, mode_d;
  logic [31:0]   counter_q, counter_d;
  logic [31:0]   target_q, target_d;
  logic          interrupt_q, interrupt_d;
  logic [15:0]   irq_total_q, irq_total_d;

  logic          fifo_full, fifo_empty, pop;
  logic [32:0]   head;
  logic [CW-1:0] fifo_count;
  logic          ack;

  irq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (ev_valid && ev_ready),
    .push_data_i ({ev_mode, ev_value}),
    .pop_i       (pop),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign ack       = is_ack(m_int_addr, m_int_byteen, ACK_ADDR);
  assign ev_ready  = !fifo_full;
  assign ev_count  = 5'(fifo_count);
  assign interrupt = interrupt_q;
  assign irq_total = irq_total_q;
  assign busy      = !fifo_empty || (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    counter_d   = counter_q;
    target_d    = target_q;
    irq_total_d = irq_total_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          mode_d    = head[32];
          counter_d = head[31:0];
          target_d  = head[31:0];
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mode_q == MODE_DELAY) begin
          if (counter_q == '0) state_d = ST_ASSERT;
          else                 counter_d = counter_q - 32'd1;
        end else if (macroscopic_pc == target_q) begin
          state_d = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (ack) begin
          state_d     = ST_IDLE;
          irq_total_d = irq_total_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered copy of "next state is ASSERT" so interrupt tracks state_q exactly.
    interrupt_d = (state_d == ST_ASSERT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_DELAY;
      counter_q   <= '0;
      target_q    <= '0;
      interrupt_q <= 1'b0;
      irq_total_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      counter_q   <= counter_d;
      target_q    <= target_d;
      interrupt_q <= interrupt_d;
      irq_total_q <= irq_total_d;
    end
  end

endmodule

// File: tb/tb_irq_gen.sv
// Directed self-checking bench for irq_gen with hand-computed expectations.
module tb_irq_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_mode;
  logic [31:0] ev_value;
  logic [31:0] macroscopic_pc;
  logic [31:0] m_int_addr;
  logic [3:0]  m_int_byteen;
  logic        interrupt;
  logic        busy;
  logic [4:0]  ev_count;
  logic [15:0] irq_total;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  irq_gen #(
    .DEPTH    (4),
    .ACK_ADDR (32'h0000_7F20)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_mode        (ev_mode),
    .ev_value       (ev_value),
    .macroscopic_pc (macroscopic_pc),
    .m_int_addr     (m_int_addr),
    .m_int_byteen   (m_int_byteen),
    .interrupt      (interrupt),
    .busy           (busy),
    .ev_count       (ev_count),
    .irq_total      (irq_total)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic mode, input logic [31:0] value);
    ev_valid = 1'b1;
    ev_mode  = mode;
    ev_value = value;
    tick();
    ev_valid = 1'b0;
  endtask

  task automatic drive_store(input logic [31:0] addr, input logic [3:0] be);
    m_int_addr   = addr;
    m_int_byteen = be;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ev_valid = 1'b0; ev_mode = 1'b0; ev_value = '0;
    macroscopic_pc = '0; m_int_addr = '0; m_int_byteen = '0;
    #1;
    tick(); tick();
    reset = 1'b0;

    check("rst_count", 32'(ev_count), 0);
    check("rst_ready", 32'(ev_ready), 1);
    check("rst_irq", 32'(interrupt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_total", 32'(irq_total), 0);

    // Delay 3 pushed at edge 0 -> interrupt after edge 5, ack at edge 9
    push(1'b0, 32'd3);                               // edge 0
    check("d3_count_e0", 32'(ev_count), 1);
    check("d3_busy_e0", 32'(busy), 1);
    tick();                                          // edge 1 pops
    check("d3_count_e1", 32'(ev_count), 0);
    check("d3_busy_e1", 32'(busy), 1);
    tick(); tick(); tick();                          // edges 2..4
    check("d3_irq_e4", 32'(interrupt), 0);
    tick();                                          // edge 5
    check("d3_irq_e5", 32'(interrupt), 1);
    drive_store(32'h0000_7F24, 4'b1111);
    tick();                                          // edge 6: wrong word
    check("wrong_addr_irq", 32'(interrupt), 1);
    check("wrong_addr_total", 32'(irq_total), 0);
    drive_store(32'h0000_7F20, 4'b0000);
    tick();                                          // edge 7: no byte enables
    check("zero_be_irq", 32'(interrupt), 1);
    drive_store(32'h0, 4'b0000);
    tick();                                          // edge 8
    drive_store(32'h0000_7F20, 4'b1111);
    tick();                                          // edge 9: ack
    drive_store(32'h0, 4'b0000);
    check("d3_irq_ack", 32'(interrupt), 0);
    check("d3_total", 32'(irq_total), 1);
    check("d3_busy_idle", 32'(busy), 0);

    // PC-match trigger
    macroscopic_pc = 32'h0000_0000;
    push(1'b1, 32'h0000_3010);
    tick();                                          // popped into WAIT
    macroscopic_pc = 32'h0000_300C; tick();
    check("pc_before_a", 32'(interrupt), 0);
    macroscopic_pc = 32'h0000_3014;
    drive_store(32'h0000_7F20, 4'b1111);             // ack in WAIT is ignored
    tick();
    drive_store(32'h0, 4'b0000);
    check("pc_before_b", 32'(interrupt), 0);
    check("ack_in_wait_total", 32'(irq_total), 1);
    macroscopic_pc = 32'h0000_3010; tick();
    check("pc_hit", 32'(interrupt), 1);
    macroscopic_pc = 32'h0000_0000;
    drive_store(32'h0000_7F20, 4'b0000); tick();
    check("pc_be0_irq", 32'(interrupt), 1);
    drive_store(32'h0000_7F21, 4'b0001); tick();     // byte offset ignored
    drive_store(32'h0, 4'b0000);
    check("pc_ack_irq", 32'(interrupt), 0);
    check("pc_ack_total", 32'(irq_total), 2);

    // Fill the queue while stuck in WAIT on an unreachable PC
    push(1'b1, 32'hDEAD_BEEC);
    tick();
    check("stuck_count0", 32'(ev_count), 0);
    for (int i = 1; i <= 5; i++) begin
      push(1'b0, 32'(i));
      check($sformatf("fill_count%0d", i), 32'(ev_count), (i > 4) ? 4 : i);
      check($sformatf("fill_ready%0d", i), 32'(ev_ready), (i >= 4) ? 0 : 1);
    end
    check("fill_irq", 32'(interrupt), 0);
    reset = 1'b1; tick(); reset = 1'b0;              // reset mid-WAIT
    check("rst_wait_count", 32'(ev_count), 0);
    check("rst_wait_busy", 32'(busy), 0);
    check("rst_wait_total", 32'(irq_total), 0);
    check("rst_wait_ready", 32'(ev_ready), 1);

    // Two back-to-back delay-0 events
    push(1'b0, 32'd0);                               // e0
    push(1'b0, 32'd0);                               // e1: push + pop
    check("b2b_count_e1", 32'(ev_count), 1);
    check("b2b_irq_e1", 32'(interrupt), 0);
    tick();                                          // e2
    check("b2b_irq_e2", 32'(interrupt), 1);
    drive_store(32'h0000_7F20, 4'b1111); tick();     // e3 ack
    drive_store(32'h0, 4'b0000);
    check("b2b_irq_e3", 32'(interrupt), 0);
    tick();                                          // e4 pop second
    check("b2b_irq_e4", 32'(interrupt), 0);
    check("b2b_count_e4", 32'(ev_count), 0);
    tick();                                          // e5
    check("b2b_irq_e5", 32'(interrupt), 1);
    drive_store(32'h0000_7F20, 4'b1111); tick();     // e6 ack
    drive_store(32'h0, 4'b0000);
    check("b2b_irq_e6", 32'(interrupt), 0);
    check("b2b_total", 32'(irq_total), 2);

    // Reset during ASSERT with two events queued
    push(1'b0, 32'd0);
    push(1'b0, 32'd0);
    push(1'b0, 32'd0);
    check("ra_irq_pre", 32'(interrupt), 1);
    check("ra_count_pre", 32'(ev_count), 2);
    reset = 1'b1; tick(); reset = 1'b0;
    check("ra_irq", 32'(interrupt), 0);
    check("ra_count", 32'(ev_count), 0);
    check("ra_busy", 32'(busy), 0);
    check("ra_total", 32'(irq_total), 0);
    tick();
    check("ra_irq_after", 32'(interrupt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/irq_gen.md
IRQ_GEN -- requirements
Module: irq_gen

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the event-queue depth (power of two, 2..16).
REQ-002 Parameter ACK_ADDR, default 32'h0000_7F20, SHALL set the interrupt-acknowledge word address.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 ev_valid  input  1  SHALL mark an event offered for enqueue.
REQ-006 ev_ready  output  1  SHALL indicate the queue can accept an event.
REQ-007 ev_mode  input  1  SHALL select the trigger type: 0 = cycle delay, 1 = PC match.
REQ-008 ev_value  input  32  SHALL carry the delay count (mode 0) or the target PC (mode 1).
REQ-009 macroscopic_pc  input  32  SHALL be the CPU macroscopic PC used for PC-match triggers.
REQ-010 m_int_addr  input  32  SHALL be the CPU interrupt-generator write address.
REQ-011 m_int_byteen  input  4  SHALL be the CPU interrupt-generator byte enables.
REQ-012 interrupt  output  1  SHALL be the external interrupt request to the CPU; registered.
REQ-013 busy  output  1  SHALL be high when the queue is non-empty or state is not IDLE.
REQ-014 ev_count  output  5  SHALL report queue occupancy.
REQ-015 irq_total  output  16  SHALL count acknowledged interrupts, wrapping at 16'hFFFF -> 0.

Function
REQ-016 Enqueue SHALL occur on a rising edge when ev_valid && ev_ready; ev_ready SHALL equal (ev_count != DEPTH).
REQ-017 Enqueue while full SHALL be dropped; queue contents and ev_count unchanged.
REQ-018 FSM states SHALL be IDLE, WAIT, ASSERT.
REQ-019 IDLE: if queue non-empty, pop the head into the active registers (mode, value -> counter/target) and go to WAIT on the same edge; there is no bypass, so an event pushed at edge k pops at edge k+1 at the earliest.
REQ-020 WAIT, mode 0: if counter == 0 go to ASSERT; otherwise decrement counter. Delay V therefore raises interrupt at edge k+2+V after the push edge k, with the queue empty beforehand.
REQ-021 WAIT, mode 1: go to ASSERT on the first edge where macroscopic_pc == target; otherwise remain in WAIT indefinitely.
REQ-022 interrupt SHALL be 1 exactly while the state is ASSERT.
REQ-023 ack SHALL be (m_int_addr[31:2] == ACK_ADDR[31:2]) && (m_int_byteen != 0).
REQ-024 ASSERT + ack: go to IDLE, increment irq_total, and drop interrupt after that same edge.
REQ-025 ack in IDLE or WAIT SHALL be ignored, with no state or counter change.
REQ-026 A simultaneous push and pop SHALL leave ev_count unchanged; a push and pop in the same cycle when full is impossible by REQ-016.
REQ-027 Back-to-back events: after an ack, the next queued event pops on the following edge; interrupt SHALL stay low for at least one cycle between events.

Reset
REQ-028 Reset SHALL empty the queue (ev_count = 0, ev_ready = 1), set state IDLE, interrupt = 0, busy = 0, irq_total = 0, and clear counter and target.
REQ-029 Reset asserted mid-WAIT or mid-ASSERT SHALL abandon the active event; interrupt is low after that edge.

Structure
REQ-030 A shared package irq_gen_pkg SHALL hold the FSM state encoding, the mode encoding (MODE_DELAY = 0, MODE_PC = 1), and the ACK_ADDR default.
REQ-031 The queue SHALL be a separate sub-module irq_fifo: synchronous FIFO, DEPTH x 33 bits, with push, pop, full, empty and count.

Verification
REQ-032 Push {mode 0, value 3} at edge 0 -> interrupt rises at edge 5; store to 0x7F20, byteen 4'b1111, at edge 9 -> interrupt low after edge 9; irq_total = 1.
REQ-033 Push {mode 1, 0x3010} -> interrupt rises on the edge where macroscopic_pc = 0x3010, not before; ack store with byteen 4'b0000 -> no effect.
REQ-034 With DEPTH = 4, push 5 events while the FSM is stuck in WAIT (PC match never hit) -> ev_ready = 0 after the 4th push, 5th dropped, ev_count = 4.
REQ-035 Queue {delay 0} and {delay 0}, ack each on its first assert cycle -> two interrupt pulses separated by at least one low cycle; irq_total = 2.
REQ-036 Assert reset during ASSERT with 2 events queued -> after that edge interrupt = 0, ev_count = 0, busy = 0, irq_total = 0.
REQ-037 Write to 0x7F24 with byteen 4'b1111 during ASSERT -> interrupt stays high.
